lcd_bus_responder: RTL

//  HD44780-compatible responder for the 8-bit LCD bus driven by the LCD controller.
//  - Decodes EN/RS/RW/DATA cycles and keeps a 2x16 DDRAM shadow with an address counter (AC).
//  - Answers busy-flag and data reads on the bus.
//  - Used as the on-chip loopback target for the IR-decoder display path, and as the bench checker.

---
 rtl/lcd_bus_responder.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: HD44780-compatible responder for the 8-bit LCD bus.
// It decodes EN/RS/RW/DATA transfers taken on the falling edge of EN. It keeps
// a 2x16 DDRAM shadow and an address counter (AC), and answers status and data
// reads on the bus.
// Optional feature macro: LCD_RX_BUSY_TIMING_EN. When it is defined, the busy
// flag follows the instruction/data execution times. When it is not defined,
// busy is only asserted while the shadow is being swept to spaces.
module lcd_bus_responder #(
    parameter int CMD_BUSY_CYCLES = 1850,
    parameter int CLR_BUSY_CYCLES = 76500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic       char_valid,
    output logic [7:0] char_code,
    output logic [6:0] char_addr,
    output logic       busy,
    output logic       disp_on,
    output logic       busy_viol
);

`ifdef LCD_RX_BUSY_TIMING_EN
    localparam logic TIMING_EN = 1'b1;
`else
    localparam logic TIMING_EN = 1'b0;
`endif

    // The timer is loaded with N-1 so that busy stays high for exactly N cycles.
    localparam logic [16:0] CMD_LOAD = 17'(CMD_BUSY_CYCLES - 1);
    localparam logic [16:0] CLR_LOAD = 17'(CLR_BUSY_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SWEEP = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    // Bus synchronisers. en_s3_q only exists for falling-edge detection.
    logic       en_s1_q, en_s2_q, en_s3_q;
    logic       rs_s1_q, rs_s2_q;
    logic       rw_s1_q, rw_s2_q;
    logic [7:0] data_s1_q, data_s2_q;

    state_t      state_q, state_d;
    logic [4:0]  sweep_cnt_q, sweep_cnt_d;
    logic [16:0] timer_q, timer_d;
    logic [6:0]  ac_q, ac_d;
    logic        id_q, id_d;
    logic        two_line_q, two_line_d;
    logic [7:0]  shadow_q [32];

    logic [7:0] data_out_q, data_out_d;
    logic       oe_q, oe_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [7:0] cmd_code_q, cmd_code_d;
    logic       char_valid_q, char_valid_d;
    logic [7:0] char_code_q, char_code_d;
    logic [6:0] char_addr_q, char_addr_d;
    logic       busy_q, busy_d;
    logic       disp_on_q, disp_on_d;
    logic       busy_viol_q, busy_viol_d;

    logic       fall_s;
    logic       busy_now_s;
    logic       shadow_we_s;
    logic [4:0] shadow_idx_s;
    logic [7:0] shadow_wdata_s;

    // Advance the address counter one step, honouring the DDRAM line wrap.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc,
                                           input logic two_line);
        logic [6:0] r;
        if (two_line) begin
            if (inc) begin
                if (ac == 7'h27)      r = 7'h40;
                else if (ac == 7'h67) r = 7'h00;
                else                  r = ac + 7'd1;
            end else begin
                if (ac == 7'h40)      r = 7'h27;
                else if (ac == 7'h00) r = 7'h67;
                else                  r = ac - 7'd1;
            end
        end else begin
            if (inc) begin
                if (ac == 7'h4F) r = 7'h00;
                else             r = ac + 7'd1;
            end else begin
                if (ac == 7'h00) r = 7'h4F;
                else             r = ac - 7'd1;
            end
        end
        return r;
    endfunction

    // Next-state decode: sweep/busy progression, then transfer handling on EN fall.
    always_comb begin
        state_d        = state_q;
        sweep_cnt_d    = sweep_cnt_q;
        timer_d        = timer_q;
        ac_d           = ac_q;
        id_d           = id_q;
        two_line_d     = two_line_q;
        disp_on_d      = disp_on_q;
        busy_viol_d    = busy_viol_q;
        cmd_valid_d    = 1'b0;
        cmd_code_d     = cmd_code_q;
        char_valid_d   = 1'b0;
        char_code_d    = char_code_q;
        char_addr_d    = char_addr_q;
        shadow_we_s    = 1'b0;
        shadow_idx_s   = sweep_cnt_q;
        shadow_wdata_s = 8'h20;

        fall_s = en_s3_q & ~en_s2_q;
        // A timer reaching zero in the same cycle as a fall releases the bus for it.
        busy_now_s = (state_q == ST_SWEEP) || ((state_q == ST_BUSY) && (timer_q != 17'd0));

        case (state_q)
            ST_SWEEP: begin
                shadow_we_s  = 1'b1;
                sweep_cnt_d  = sweep_cnt_q + 5'd1;
                if (timer_q != 17'd0) timer_d = timer_q - 17'd1;
                else                  timer_d = timer_q;
                if (sweep_cnt_q == 5'd31) begin
                    if (timer_q == 17'd0) state_d = ST_IDLE;
                    else                  state_d = ST_BUSY;
                end else begin
                    state_d = ST_SWEEP;
                end
            end
            ST_BUSY: begin
                if (timer_q == 17'd0) state_d = ST_IDLE;
                else                  timer_d = timer_q - 17'd1;
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fall_s && !rw_s2_q && busy_now_s) begin
            busy_viol_d = 1'b1;
        end else if (fall_s && !rw_s2_q) begin
            // Any accepted write starts the short execution window; clear/home override it.
            state_d = TIMING_EN ? ST_BUSY : ST_IDLE;
            timer_d = TIMING_EN ? CMD_LOAD : 17'd0;
            if (!rs_s2_q) begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = data_s2_q;
                if (data_s2_q[7]) begin
                    ac_d = data_s2_q[6:0];
                end else if (data_s2_q[6]) begin
                    ac_d = ac_q;
                end else if (data_s2_q[5]) begin
                    two_line_d = data_s2_q[3];
                end else if (data_s2_q[4]) begin
                    if (!data_s2_q[3]) ac_d = ac_step(ac_q, data_s2_q[2], two_line_q);
                    else               ac_d = ac_q;
                end else if (data_s2_q[3]) begin
                    disp_on_d = data_s2_q[2];
                end else if (data_s2_q[2]) begin
                    id_d = data_s2_q[1];
                end else if (data_s2_q[1]) begin
                    ac_d    = 7'h00;
                    state_d = TIMING_EN ? ST_BUSY : ST_IDLE;
                    timer_d = TIMING_EN ? CLR_LOAD : 17'd0;
                end else if (data_s2_q[0]) begin
                    ac_d        = 7'h00;
                    id_d        = 1'b1;
                    state_d     = ST_SWEEP;
                    sweep_cnt_d = 5'd0;
                    timer_d     = TIMING_EN ? CLR_LOAD : 17'd0;
                end else begin
                    ac_d = ac_q;
                end
            end else begin
                if (ac_q[5:0] < 6'd16) begin
                    shadow_we_s    = 1'b1;
                    shadow_idx_s   = {ac_q[6], ac_q[3:0]};
                    shadow_wdata_s = data_s2_q;
                end else begin
                    shadow_we_s = 1'b0;
                end
                char_valid_d = 1'b1;
                char_code_d  = data_s2_q;
                char_addr_d  = ac_q;
                ac_d         = ac_step(ac_q, id_q, two_line_q);
            end
        end else if (fall_s && rs_s2_q) begin
            ac_d = ac_step(ac_q, id_q, two_line_q);
        end else begin
            ac_d = ac_d;
        end

        busy_d    = (state_d != ST_IDLE);
        oe_d      = en_s2_q & rw_s2_q;
        rd_data_d = shadow_q[rd_addr];
        if (rs_s2_q) data_out_d = shadow_q[{ac_q[6], ac_q[3:0]}];
        else         data_out_d = {busy_q, ac_q};
    end

    // Control state, synchronisers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_s1_q      <= 1'b0;
            en_s2_q      <= 1'b0;
            en_s3_q      <= 1'b0;
            rs_s1_q      <= 1'b0;
            rs_s2_q      <= 1'b0;
            rw_s1_q      <= 1'b0;
            rw_s2_q      <= 1'b0;
            data_s1_q    <= 8'h00;
            data_s2_q    <= 8'h00;
            state_q      <= ST_SWEEP;
            sweep_cnt_q  <= 5'd0;
            timer_q      <= 17'd0;
            ac_q         <= 7'h00;
            id_q         <= 1'b1;
            two_line_q   <= 1'b1;
            data_out_q   <= 8'h00;
            oe_q         <= 1'b0;
            rd_data_q    <= 8'h00;
            cmd_valid_q  <= 1'b0;
            cmd_code_q   <= 8'h00;
            char_valid_q <= 1'b0;
            char_code_q  <= 8'h00;
            char_addr_q  <= 7'h00;
            busy_q       <= 1'b0;
            disp_on_q    <= 1'b0;
            busy_viol_q  <= 1'b0;
        end else begin
            en_s1_q      <= lcd_en;
            en_s2_q      <= en_s1_q;
            en_s3_q      <= en_s2_q;
            rs_s1_q      <= lcd_rs;
            rs_s2_q      <= rs_s1_q;
            rw_s1_q      <= lcd_rw;
            rw_s2_q      <= rw_s1_q;
            data_s1_q    <= lcd_data_in;
            data_s2_q    <= data_s1_q;
            state_q      <= state_d;
            sweep_cnt_q  <= sweep_cnt_d;
            timer_q      <= timer_d;
            ac_q         <= ac_d;
            id_q         <= id_d;
            two_line_q   <= two_line_d;
            data_out_q   <= data_out_d;
            oe_q         <= oe_d;
            rd_data_q    <= rd_data_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_code_q   <= cmd_code_d;
            char_valid_q <= char_valid_d;
            char_code_q  <= char_code_d;
            char_addr_q  <= char_addr_d;
            busy_q       <= busy_d;
            disp_on_q    <= disp_on_d;
            busy_viol_q  <= busy_viol_d;
        end
    end

    // DDRAM shadow storage; contents are rebuilt by the sweep, so there is no reset.
    always_ff @(posedge clk) begin
        if (!rst && shadow_we_s) begin
            shadow_q[shadow_idx_s] <= shadow_wdata_s;
        end
    end

    assign lcd_data_out = data_out_q;
    assign lcd_data_oe  = oe_q;
    assign rd_data      = rd_data_q;
    assign cmd_valid    = cmd_valid_q;
    assign cmd_code     = cmd_code_q;
    assign char_valid   = char_valid_q;
    assign char_code    = char_code_q;
    assign char_addr    = char_addr_q;
    assign busy         = busy_q;
    assign disp_on      = disp_on_q;
    assign busy_viol    = busy_viol_q;

endmodule
